dram_refresh_arbiter: RTL and testbench

- Owns the fast-RAM DRAM banks between CPU cycles and CAS-before-RAS (CBR) refresh.
- Replaces AS-count-based refresh with a CLKCPU-timed interval counter and a bounded backlog of owed refreshes.
- Hides refresh in idle bus time or non-RAM cycles. Stalls a RAM cycle only when the backlog is full.
- Sits beside the fast-RAM cycle controller, which may start a RAM cycle only while CPU_GNT is high.

---
 rtl/fastmem_pkg.sv | 27 ++
 rtl/refresh_timer.sv | 53 +++++
 rtl/dram_refresh_arbiter.sv | 115 +++++++++++
 tb/tb_dram_refresh_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fastmem_pkg.sv
// Shared fast-RAM definitions: arbiter state encoding and default DRAM timing.
package fastmem_pkg;

  // Default refresh timing, in CLKCPU cycles (25 MHz).
  localparam int unsigned RefreshIntervalDef = 390;  // 15.6 us per owed refresh
  localparam int unsigned MaxPendingDef      = 4;
  localparam int unsigned RasCyclesDef       = 3;
  localparam int unsigned PrechargeDef       = 2;

  // Width of the backlog count seen on the PENDING port.
  localparam int unsigned PendingW = 3;

  // DRAM ownership states shared with the fast-RAM cycle controller.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StCpu    = 3'd1,
    StCbrCas = 3'd2,
    StCbrRas = 3'd3,
    StPrech  = 3'd4
  } fm_state_e;

  // Counter width able to hold values 0 .. n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/refresh_timer.sv
// Refresh interval timer: issues a tick every REFRESH_INTERVAL clocks and keeps a
// saturating backlog of owed refreshes plus a sticky overflow flag.
module refresh_timer
  import fastmem_pkg::*;
#(
  parameter int unsigned REFRESH_INTERVAL = RefreshIntervalDef,
  parameter int unsigned MAX_PENDING      = MaxPendingDef
) (
  input  logic                CLKCPU,
  input  logic                RESET,
  input  logic                start,    // a CBR sequence begins on this edge
  output logic [PendingW-1:0] pending,
  output logic                urgent,
  output logic                ref_ovf
);

  localparam int unsigned CntW = cnt_width(REFRESH_INTERVAL);
  localparam logic [CntW-1:0]     Reload  = CntW'(REFRESH_INTERVAL - 1);
  localparam logic [PendingW-1:0] MaxPend = PendingW'(MAX_PENDING);

  logic [CntW-1:0]     cnt_q;
  logic [PendingW-1:0] pending_q;
  logic                ovf_q;
  logic                tick;

  // Tick in the cycle the counter sits at zero; it reloads on the same edge.
  always_comb begin
    tick   = (cnt_q == '0);
    urgent = (pending_q == MaxPend);
  end

  // Interval counter, saturating backlog and sticky overflow.
  always_ff @(posedge CLKCPU or negedge RESET) begin
    if (!RESET) begin
      cnt_q     <= Reload;
      pending_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      cnt_q <= tick ? Reload : cnt_q - 1'b1;
      // Simultaneous tick and start cancel, even at saturation.
      unique case ({tick, start})
        2'b10: if (pending_q != MaxPend) pending_q <= pending_q + 1'b1;
        2'b01: pending_q <= pending_q - 1'b1;
        default: pending_q <= pending_q;
      endcase
      if (tick && (pending_q == MaxPend)) ovf_q <= 1'b1;
    end
  end

  assign pending = pending_q;
  assign ref_ovf = ovf_q;

endmodule

// File: rtl/dram_refresh_arbiter.sv
// Fast-RAM DRAM owner: arbitrates between CPU RAM cycles and CBR refresh, hiding
// refresh in idle or non-RAM bus time and stalling the CPU only when refresh is urgent.
module dram_refresh_arbiter
  import fastmem_pkg::*;
#(
  parameter int unsigned REFRESH_INTERVAL = RefreshIntervalDef,
  parameter int unsigned MAX_PENDING      = MaxPendingDef,
  parameter int unsigned RAS_CYCLES       = RasCyclesDef,
  parameter int unsigned PRECHARGE        = PrechargeDef
) (
  input  logic                CLKCPU,
  input  logic                RESET,
  input  logic                AS20,
  input  logic                RAM_SEL_N,
  output logic                CPU_GNT,
  output logic                REF_ACTIVE,
  output logic [1:0]          REF_RAS_N,
  output logic [3:0]          REF_CAS_N,
  output logic [PendingW-1:0] PENDING,
  output logic                REF_OVF
);

  localparam int unsigned TimW = cnt_width((RAS_CYCLES > PRECHARGE) ? RAS_CYCLES : PRECHARGE);
  localparam logic [TimW-1:0] RasLoad  = TimW'(RAS_CYCLES - 1);
  localparam logic [TimW-1:0] PrchLoad = TimW'(PRECHARGE - 1);

  fm_state_e       state_q;
  logic [TimW-1:0] tim_q;
  logic            urgent;
  logic            ram_req;
  logic            start;

  refresh_timer #(
    .REFRESH_INTERVAL (REFRESH_INTERVAL),
    .MAX_PENDING      (MAX_PENDING)
  ) u_refresh_timer (
    .CLKCPU  (CLKCPU),
    .RESET   (RESET),
    .start   (start),
    .pending (PENDING),
    .urgent  (urgent),
    .ref_ovf (REF_OVF)
  );

  // Refresh start decision from IDLE; refresh beats any simultaneous CPU request.
  always_comb begin
    ram_req = !AS20 && !RAM_SEL_N;
    start   = (state_q == StIdle) && (PENDING != '0) && (AS20 || RAM_SEL_N || urgent);
  end

  // Arbiter FSM with registered grant and strobe outputs.
  always_ff @(posedge CLKCPU or negedge RESET) begin
    if (!RESET) begin
      state_q    <= StIdle;
      tim_q      <= '0;
      CPU_GNT    <= 1'b0;
      REF_ACTIVE <= 1'b0;
      REF_RAS_N  <= 2'b11;
      REF_CAS_N  <= 4'hF;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StCbrCas;
            REF_ACTIVE <= 1'b1;
            REF_CAS_N  <= 4'h0;
          end else if (ram_req) begin
            state_q <= StCpu;
            CPU_GNT <= 1'b1;
          end
        end
        StCpu: begin
          if (AS20) begin
            state_q <= StPrech;
            CPU_GNT <= 1'b0;
            tim_q   <= PrchLoad;
          end
        end
        StCbrCas: begin
          // CAS has led RAS by one cycle; now drop RAS with CAS still low.
          state_q   <= StCbrRas;
          REF_RAS_N <= 2'b00;
          tim_q     <= RasLoad;
        end
        StCbrRas: begin
          if (tim_q == '0) begin
            state_q   <= StPrech;
            REF_RAS_N <= 2'b11;
            REF_CAS_N <= 4'hF;
            tim_q     <= PrchLoad;
          end else begin
            tim_q <= tim_q - 1'b1;
          end
        end
        StPrech: begin
          // REF_ACTIVE is still high here only when precharge follows a refresh.
          if (tim_q == '0) begin
            state_q    <= StIdle;
            REF_ACTIVE <= 1'b0;
          end else begin
            tim_q <= tim_q - 1'b1;
          end
        end
        default: begin
          state_q    <= StIdle;
          CPU_GNT    <= 1'b0;
          REF_ACTIVE <= 1'b0;
          REF_RAS_N  <= 2'b11;
          REF_CAS_N  <= 4'hF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_refresh_arbiter.sv
// Directed bench for dram_refresh_arbiter with a short refresh interval of 8 clocks.
module tb_dram_refresh_arbiter;

  logic       CLKCPU;
  logic       RESET;
  logic       AS20;
  logic       RAM_SEL_N;
  logic       CPU_GNT;
  logic       REF_ACTIVE;
  logic [1:0] REF_RAS_N;
  logic [3:0] REF_CAS_N;
  logic [2:0] PENDING;
  logic       REF_OVF;

  int n_cmp = 0;
  int n_err = 0;
  int e     = 0;  // rising edges since reset release

  dram_refresh_arbiter #(
    .REFRESH_INTERVAL (8),
    .MAX_PENDING      (4),
    .RAS_CYCLES       (3),
    .PRECHARGE        (2)
  ) dut (
    .CLKCPU     (CLKCPU),
    .RESET      (RESET),
    .AS20       (AS20),
    .RAM_SEL_N  (RAM_SEL_N),
    .CPU_GNT    (CPU_GNT),
    .REF_ACTIVE (REF_ACTIVE),
    .REF_RAS_N  (REF_RAS_N),
    .REF_CAS_N  (REF_CAS_N),
    .PENDING    (PENDING),
    .REF_OVF    (REF_OVF)
  );

  initial CLKCPU = 1'b0;
  always #5 CLKCPU = ~CLKCPU;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, e, obs, exp);
    end
  endtask

  task automatic go_to(input int target);
    while (e < target) begin
      @(posedge CLKCPU);
      #1;
      e++;
    end
  endtask

  // Grant and refresh ownership must never overlap.
  always @(negedge CLKCPU) begin
    if (RESET === 1'b1) begin
      n_cmp++;
      assert (!(CPU_GNT && REF_ACTIVE)) else begin
        n_err++;
        $error("FAIL exclusive at edge %0d: observed gnt=%b act=%b expected not both", e,
               CPU_GNT, REF_ACTIVE);
      end
    end
  end

  initial begin
    RESET     = 1'b0;
    AS20      = 1'b1;
    RAM_SEL_N = 1'b1;
    repeat (2) @(posedge CLKCPU);
    #1;
    chk("rst_gnt", 8'(CPU_GNT), 8'd0);
    chk("rst_act", 8'(REF_ACTIVE), 8'd0);
    chk("rst_ras", 8'(REF_RAS_N), 8'h3);
    chk("rst_cas", 8'(REF_CAS_N), 8'hF);
    chk("rst_pend", 8'(PENDING), 8'd0);
    chk("rst_ovf", 8'(REF_OVF), 8'd0);
    @(negedge CLKCPU);
    RESET = 1'b1;

    // Idle bus: first tick on edge 8, refresh starts edge 9.
    go_to(7);
    chk("pre_tick_pend", 8'(PENDING), 8'd0);
    go_to(8);
    chk("tick_pend", 8'(PENDING), 8'd1);
    chk("tick_cas", 8'(REF_CAS_N), 8'hF);
    go_to(9);
    chk("cas_low", 8'(REF_CAS_N), 8'h0);
    chk("cas_ras_high", 8'(REF_RAS_N), 8'h3);
    chk("cas_act", 8'(REF_ACTIVE), 8'd1);
    chk("cas_pend", 8'(PENDING), 8'd0);
    go_to(10);
    chk("ras_low1", 8'(REF_RAS_N), 8'h0);
    chk("ras_cas_held", 8'(REF_CAS_N), 8'h0);
    go_to(12);
    chk("ras_low3", 8'(REF_RAS_N), 8'h0);
    go_to(13);
    chk("ras_release", 8'(REF_RAS_N), 8'h3);
    chk("cas_release", 8'(REF_CAS_N), 8'hF);
    chk("prech_act", 8'(REF_ACTIVE), 8'd1);
    go_to(14);
    chk("prech_act2", 8'(REF_ACTIVE), 8'd1);
    go_to(15);
    chk("act_drop", 8'(REF_ACTIVE), 8'd0);

    // Non-RAM CPU cycle: refresh is hidden under it.
    AS20      = 1'b0;
    RAM_SEL_N = 1'b1;
    go_to(16);
    chk("opp_pend", 8'(PENDING), 8'd1);
    chk("opp_idle_gnt", 8'(CPU_GNT), 8'd0);
    go_to(17);
    chk("opp_cas", 8'(REF_CAS_N), 8'h0);
    chk("opp_act", 8'(REF_ACTIVE), 8'd1);
    chk("opp_gnt", 8'(CPU_GNT), 8'd0);
    chk("opp_pend_dec", 8'(PENDING), 8'd0);
    go_to(23);
    chk("opp_done_act", 8'(REF_ACTIVE), 8'd0);

    // RAM cycle with nothing owed: grant one cycle later, held through ticks.
    RAM_SEL_N = 1'b0;
    #1;
    chk("gnt_latency", 8'(CPU_GNT), 8'd0);
    go_to(24);
    chk("gnt_on", 8'(CPU_GNT), 8'd1);
    chk("gnt_pend1", 8'(PENDING), 8'd1);
    go_to(47);
    chk("cpu_pend3", 8'(PENDING), 8'd3);
    chk("cpu_ras_idle", 8'(REF_RAS_N), 8'h3);
    chk("cpu_gnt_held", 8'(CPU_GNT), 8'd1);
    go_to(48);
    chk("sat_pend4", 8'(PENDING), 8'd4);
    go_to(55);
    chk("ovf_not_yet", 8'(REF_OVF), 8'd0);
    go_to(56);
    chk("ovf_set", 8'(REF_OVF), 8'd1);
    chk("sat_hold", 8'(PENDING), 8'd4);
    chk("sat_ras_idle", 8'(REF_RAS_N), 8'h3);
    chk("sat_cas_idle", 8'(REF_CAS_N), 8'hF);

    // End CPU cycle, immediately request RAM again with the backlog full.
    go_to(61);
    AS20 = 1'b1;
    go_to(62);
    chk("cpu_end_gnt", 8'(CPU_GNT), 8'd0);
    chk("cpu_prech_act", 8'(REF_ACTIVE), 8'd0);
    AS20 = 1'b0;
    go_to(64);
    chk("urg_idle_gnt", 8'(CPU_GNT), 8'd0);
    chk("urg_idle_pend", 8'(PENDING), 8'd4);
    go_to(65);
    chk("urg_cas", 8'(REF_CAS_N), 8'h0);
    chk("urg_gnt_wait", 8'(CPU_GNT), 8'd0);
    chk("urg_pend3", 8'(PENDING), 8'd3);
    go_to(68);
    chk("urg_ras", 8'(REF_RAS_N), 8'h0);
    chk("urg_ras_gnt", 8'(CPU_GNT), 8'd0);
    go_to(71);
    chk("urg_idle2_act", 8'(REF_ACTIVE), 8'd0);
    chk("urg_idle2_gnt", 8'(CPU_GNT), 8'd0);
    chk("urg_idle2_pend", 8'(PENDING), 8'd3);
    go_to(72);
    chk("urg_granted", 8'(CPU_GNT), 8'd1);
    chk("urg_tick_pend", 8'(PENDING), 8'd4);
    chk("ovf_sticky", 8'(REF_OVF), 8'd1);

    // Release the bus, let a refresh start, then reset in the middle of RAS.
    AS20 = 1'b1;
    go_to(73);
    chk("rel_gnt", 8'(CPU_GNT), 8'd0);
    go_to(76);
    chk("rr_cas", 8'(REF_CAS_N), 8'h0);
    chk("rr_pend", 8'(PENDING), 8'd3);
    go_to(78);
    chk("rr_ras_low", 8'(REF_RAS_N), 8'h0);
    #2;
    RESET = 1'b0;
    #1;
    chk("arst_ras", 8'(REF_RAS_N), 8'h3);
    chk("arst_cas", 8'(REF_CAS_N), 8'hF);
    chk("arst_pend", 8'(PENDING), 8'd0);
    chk("arst_act", 8'(REF_ACTIVE), 8'd0);
    chk("arst_ovf", 8'(REF_OVF), 8'd0);
    chk("arst_gnt", 8'(CPU_GNT), 8'd0);
    repeat (2) @(posedge CLKCPU);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
